// File: rtl/button_step_ctrl_if.sv
// Button inputs and counter-facing step outputs of button_step_ctrl.
// master = stimulus/board side, slave = the controller.
interface button_step_ctrl_if;
    logic btn_up;
    logic btn_down;
    logic enable;
    logic direction;
    logic lockout;

    modport master (output btn_up, btn_down, input enable, direction, lockout);
    modport slave  (input btn_up, btn_down, output enable, direction, lockout);
endinterface

// File: rtl/button_step_ctrl.sv
// Push-button front end for the up/down counter: sync + debounce per button,
// then a step/auto-repeat FSM that rejects simultaneous presses.

// One button lane: 2-flop synchroniser followed by a stable-run debouncer.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);
    logic        s1, s2;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            deb <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any sample agreeing with deb restarts the stability run.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

module button_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    button_step_ctrl_if.slave   bus
);
    localparam int NUM_BTNS = 2;
    localparam int DN       = 0;
    localparam int UP       = 1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKOUT} state_t;

    logic [NUM_BTNS-1:0] raw, deb, deb_q, rise;
    state_t              state;
    logic [31:0]         timer, timer_last;
    logic                enable_r, dir_r, lock_r;
    logic                act, oth;

    assign raw = {bus.btn_up, bus.btn_down};

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_BTNS-1:0] (
        .clk (clk),
        .rst (rst),
        .raw (raw),
        .deb (deb)
    );

    assign rise       = deb & ~deb_q;
    // The held button is the one matching the last stepped direction.
    assign act        = dir_r ? deb[UP] : deb[DN];
    assign oth        = dir_r ? deb[DN] : deb[UP];
    assign timer_last = (state == DELAY) ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            enable_r <= 1'b0;
            dir_r    <= 1'b1;
            lock_r   <= 1'b0;
            deb_q    <= '0;
        end else begin
            deb_q    <= deb;
            enable_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (&deb) begin
                        state  <= LOCKOUT;
                        lock_r <= 1'b1;
                    end else if (rise[UP]) begin
                        enable_r <= 1'b1;
                        dir_r    <= 1'b1;
                        timer    <= '0;
                        state    <= DELAY;
                    end else if (rise[DN]) begin
                        enable_r <= 1'b1;
                        dir_r    <= 1'b0;
                        timer    <= '0;
                        state    <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    // Release, then lockout, both win over a timer expiry.
                    if (!act) begin
                        state <= IDLE;
                    end else if (oth) begin
                        state  <= LOCKOUT;
                        lock_r <= 1'b1;
                    end else if (timer == timer_last) begin
                        enable_r <= 1'b1;
                        timer    <= '0;
                        state    <= REPEAT;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                LOCKOUT: begin
                    if (~|deb) begin
                        state  <= IDLE;
                        lock_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enable    = enable_r;
    assign bus.direction = dir_r;
    assign bus.lockout   = lock_r;
endmodule

// File: tb/tb_button_step_ctrl.sv
// Scenario tasks plus a randomized run, all checked cycle by cycle against
// an event-level reference model of the step controller.
module tb_button_step_ctrl;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk, rst;
    button_step_ctrl_if bus();

    button_step_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: raw sample history, debounced levels, and a press
    // record (idle / held since edge press_n / locked).
    bit qu[$], qd[$];
    bit deb_u, deb_d, debp_u, debp_d;
    int mode;          // 0 idle, 1 held, 2 locked
    bit hold_dir;
    int n, press_n;
    bit e_en, e_dir, e_lock;

    function automatic void model_reset();
        qu.delete(); qd.delete();
        deb_u = 0; deb_d = 0; debp_u = 0; debp_d = 0;
        mode = 0; hold_dir = 1; n = 0; press_n = 0;
        e_en = 0; e_dir = 1; e_lock = 0;
    endfunction

    // Level flips once the last D synchronised samples all disagree with it.
    function automatic bit settle(input bit q[$], input bit deb);
        if (q.size() < D + 2) return deb;
        for (int i = q.size() - 2 - D; i <= q.size() - 3; i++)
            if (q[i] == deb) return deb;
        return ~deb;
    endfunction

    function automatic void model_step(input bit u, input bit d);
        int age;
        bit act, oth;
        if (rst) begin
            model_reset();
            return;
        end
        n++;
        e_en = 0;
        case (mode)
            0: begin
                if (deb_u && deb_d) mode = 2;
                else if (deb_u && !debp_u) begin
                    e_en = 1; e_dir = 1; hold_dir = 1; mode = 1; press_n = n;
                end else if (deb_d && !debp_d) begin
                    e_en = 1; e_dir = 0; hold_dir = 0; mode = 1; press_n = n;
                end
            end
            1: begin
                act = hold_dir ? deb_u : deb_d;
                oth = hold_dir ? deb_d : deb_u;
                if (!act) mode = 0;
                else if (oth) mode = 2;
                else begin
                    age = n - press_n;
                    if (age == RD || (age > RD && (age - RD) % RP == 0)) e_en = 1;
                end
            end
            default: if (!deb_u && !deb_d) mode = 0;
        endcase
        e_lock = (mode == 2);
        debp_u = deb_u;
        debp_d = deb_d;
        qu.push_back(u);
        qd.push_back(d);
        deb_u = settle(qu, deb_u);
        deb_d = settle(qd, deb_d);
        while (qu.size() > D + 4) void'(qu.pop_front());
        while (qd.size() > D + 4) void'(qd.pop_front());
    endfunction

    // Drive one cycle of raw inputs; returns at the following falling edge.
    task automatic cyc(input bit u, input bit d);
        bus.btn_up   = u;
        bus.btn_down = d;
        @(posedge clk);
        model_step(u, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== 3'b010) begin
                miscompares++;
                $display("FAIL reset k=%0d got %b exp 010", k, {bus.enable, bus.direction, bus.lockout});
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
        end
    endtask

    task automatic test_clean_press();
        int exp_t[4] = '{7, 27, 32, 37};
        int pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc(k <= 40, 1'b0);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL press k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) begin
                pulses++;
                vectors++;
                if (pulses <= 4 && (k != exp_t[pulses-1] || bus.direction !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL press_time pulse %0d at k=%0d dir=%b exp k=%0d dir=1", pulses, k, bus.direction, exp_t[pulses-1]);
                end
                if (k > 40 + D + 1) begin
                    miscompares++;
                    $display("FAIL press_after_release pulse at k=%0d exp none after %0d", k, 40 + D + 1);
                end
            end
        end
        vectors++;
        if (pulses < 4) begin
            miscompares++;
            $display("FAIL press_count got %0d exp >=4", pulses);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat = 8'b1110_1101;
        int pulses = 0;
        for (int k = 0; k < 24; k++) begin
            cyc(1'b0, (k < 8) ? pat[k] : 1'b0);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL bounce k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || bus.direction !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_reject pulses=%0d dir=%b exp 0 pulses dir=1", pulses, bus.direction);
        end
    endtask

    task automatic test_tap_down();
        logic [7:0] cnt8 = 8'd0;
        int pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            cyc(1'b0, k <= 10);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL tap k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) begin
                pulses++;
                cnt8 = bus.direction ? cnt8 + 8'd1 : cnt8 - 8'd1;
            end
        end
        vectors++;
        if (pulses != 1 || cnt8 !== 8'd255) begin
            miscompares++;
            $display("FAIL tap_wrap pulses=%0d count=%0d exp 1 pulse count=255", pulses, cnt8);
        end
    endtask

    task automatic test_lockout_seq();
        int pulses = 0;
        for (int k = 1; k <= 80; k++) begin
            cyc(k <= 55, k >= 13 && k <= 30);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL lock k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) begin
                pulses++;
                vectors++;
                if (k != 7 || bus.direction !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lock_pulse at k=%0d dir=%b exp only k=7 dir=1", k, bus.direction);
                end
            end
            if (k == 40 || k == 80) begin
                vectors++;
                if (bus.lockout !== (k == 40)) begin
                    miscompares++;
                    $display("FAIL lock_level k=%0d got %b exp %b", k, bus.lockout, k == 40);
                end
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL lock_count got %0d exp 1", pulses);
        end
    endtask

    task automatic test_same_cycle();
        int pulses = 0;
        int first_lock = 0;
        for (int k = 1; k <= 35; k++) begin
            cyc(k <= 20, k <= 20);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL both k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) pulses++;
            if (bus.lockout === 1'b1 && first_lock == 0) first_lock = k;
        end
        vectors++;
        if (pulses != 0 || first_lock != 7 || bus.lockout !== 1'b0) begin
            miscompares++;
            $display("FAIL both_reject pulses=%0d lock_at=%0d lock_end=%b exp 0, 7, 0", pulses, first_lock, bus.lockout);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        int first = 0;
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b0, 1'b1);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL arst_pre k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
        end
        // Mid-cycle, while the k=32 repeat pulse is on the output.
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.enable, bus.direction, bus.lockout} !== 3'b010) begin
            miscompares++;
            $display("FAIL arst_now got %b exp 010", {bus.enable, bus.direction, bus.lockout});
        end
        model_reset();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== 3'b010) begin
                miscompares++;
                $display("FAIL arst_hold k=%0d got %b exp 010", k, {bus.enable, bus.direction, bus.lockout});
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cyc(1'b0, 1'b1);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL arst_post k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
            if (bus.enable === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        vectors++;
        if (pulses != 1 || first != 7 || bus.direction !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_fresh pulses=%0d at=%0d dir=%b exp 1 at 7 dir=0", pulses, first, bus.direction);
        end
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit u = 0, d = 0;
        int cu = 1, cd = 1;
        for (int k = 0; k < 3000; k++) begin
            if (--cu == 0) begin
                u  = 1'($urandom_range(0, 1));
                cu = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
            end
            if (--cd == 0) begin
                d  = 1'($urandom_range(0, 1));
                cd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
            end
            cyc(u, d);
            vectors++;
            if ({bus.enable, bus.direction, bus.lockout} !== {e_en, e_dir, e_lock}) begin
                miscompares++;
                $display("FAIL random k=%0d got %b exp %b", k, {bus.enable, bus.direction, bus.lockout}, {e_en, e_dir, e_lock});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_tap_down();
        test_lockout_seq();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
